// File: rtl/db_read_addr_gen_if.sv
// -----------------------------------------------------------------------------
// db_read_addr_gen_if
//   Read-address handshake between the address generator and the double-buffer
//   memory core. The producer presents addr_out/addr_valid. The consumer
//   returns addr_ready. A transfer happens on a rising clock edge when
//   addr_valid and addr_ready are both high.
//
//   Signals:
//     addr_out    [AW-1:0]  read address (maps to memory core addr_in)
//     addr_valid            addr_out is valid (maps to memory core ren_in)
//     addr_ready            consumer accepts addr_out this cycle
//
//   Modports:
//     master  address generator side
//     slave   memory core side
// -----------------------------------------------------------------------------
interface db_read_addr_gen_if #(
    parameter int AW = 16
);
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          addr_ready;

    modport master (output addr_out, output addr_valid, input addr_ready);
    modport slave  (input addr_out, input addr_valid, output addr_ready);
endinterface

// File: rtl/db_read_addr_gen.sv
// -----------------------------------------------------------------------------
// db_read_addr_gen
//   Multi-dimensional read address generator for the double-buffer memory
//   core. It walks up to NUM_DIMS nested loops, each with its own stride and
//   range, starting from starting_addr. Addresses go out on a valid/ready
//   handshake. done pulses once per sweep, one cycle after the final address
//   is accepted.
//
//   Optional feature macro: DB_ADDR_GEN_CIRCULAR_EN
//     When defined, the block gains a circular_en input, which is latched on
//     start. With circular_en=1 the sweep wraps back to starting_addr with no
//     gap, and done pulses on every wrap. The block leaves RUN only through
//     reset or flush.
//
//   Ports:
//     clk             rising-edge clock
//     reset           synchronous, active-high
//     clk_en          0 = hold all state
//     flush           synchronous soft clear (same effect as reset)
//     start           begin one sweep (accepted in IDLE or DONE)
//     dimensionality  active dims (0 -> 1, >NUM_DIMS -> NUM_DIMS)
//     starting_addr   base address of the sweep
//     strides         packed, dim d at [d*AW +: AW]
//     ranges          packed, dim d at [d*RW +: RW] (0 -> 1)
//     circular_en     (macro only) wrap sweeps endlessly
//     rd              read-address handshake (master side)
//     busy            1 while in RUN
//     done            one-cycle pulse at sweep completion
// -----------------------------------------------------------------------------
module db_read_addr_gen #(
    parameter int NUM_DIMS = 6,
    parameter int AW       = 16,
    parameter int RW       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   start,
    input  logic [3:0]             dimensionality,
    input  logic [AW-1:0]          starting_addr,
    input  logic [NUM_DIMS*AW-1:0] strides,
    input  logic [NUM_DIMS*RW-1:0] ranges,
`ifdef DB_ADDR_GEN_CIRCULAR_EN
    input  logic                   circular_en,
`endif
    db_read_addr_gen_if.master     rd,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_q;

    // Configuration latched on an accepted start.
    logic [AW-1:0] base_q;
    logic [AW-1:0] stride_q [NUM_DIMS];
    logic [RW-1:0] max_q    [NUM_DIMS];   // last index per dim; 0 for inactive dims
    logic          circ_q;

    // Loop state. off_q[d] tracks idx_q[d]*stride_q[d] mod 2^AW incrementally.
    logic [RW-1:0] idx_q    [NUM_DIMS];
    logic [AW-1:0] off_q    [NUM_DIMS];

    logic [AW-1:0] addr_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    // Next-state values for one advance of the index vector.
    logic [RW-1:0] idx_d    [NUM_DIMS];
    logic [AW-1:0] off_d    [NUM_DIMS];
    logic [AW-1:0] addr_d;
    logic          last_d;                // carry out of the top dim: sweep complete
    logic [RW-1:0] max_d    [NUM_DIMS];   // per-dim last index derived from the inputs

    logic [3:0]    dims_eff;
    logic [RW-1:0] rng;
    logic          carry;
    logic [AW-1:0] sum;
    logic          start_ok;
    logic          xfer;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign xfer     = valid_q && rd.addr_ready;

`ifdef DB_ADDR_GEN_CIRCULAR_EN
    logic circ_in;
    assign circ_in = circular_en;
`else
    logic circ_in;
    assign circ_in = 1'b0;
`endif

    // Normalise the configuration inputs before they are latched.
    // Inactive dims get a last index of 0, so they always carry straight
    // through. The carry out of dim NUM_DIMS-1 then marks the end of the
    // active loop nest.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
        dims_eff = dimensionality;
        rng      = '0;
        if (dimensionality == 4'd0) begin
            dims_eff = 4'd1;
        end else if (dimensionality > 4'(NUM_DIMS)) begin
            dims_eff = 4'(NUM_DIMS);
        end
        for (int d = 0; d < NUM_DIMS; d++) begin
            rng = ranges[d*RW +: RW];
            if (d < int'(dims_eff) && rng != '0) begin
                max_d[d] = rng - RW'(1);
            end else begin
                max_d[d] = '0;
            end
        end
    end

    // Odometer advance: the lowest dim increments; any dim at its last index
    // wraps to 0 and passes the carry upward. The new address is the base
    // plus the per-dim offsets, which is the closed form built from adders.
    always_comb begin
        // NOTE: blocking assignments here on purpose; carry and sum must ripple through the loop in one evaluation.
        carry = 1'b1;
        sum   = base_q;
        for (int d = 0; d < NUM_DIMS; d++) begin
            idx_d[d] = idx_q[d];
            off_d[d] = off_q[d];
            if (carry) begin
                if (idx_q[d] == max_q[d]) begin
                    idx_d[d] = '0;
                    off_d[d] = '0;
                end else begin
                    idx_d[d] = idx_q[d] + RW'(1);
                    off_d[d] = off_q[d] + stride_q[d];
                    carry    = 1'b0;
                end
            end
            sum = sum + off_d[d];
        end
        last_d = carry;
        addr_d = sum;
    end

    // Configuration latches. These have no reset: they are read only in RUN,
    // and RUN is reachable only through a start, which loads them.
    always_ff @(posedge clk) begin
        // NOTE: configuration storage is deliberately left unreset; only control state needs a reset value.
        if (clk_en && !reset && !flush && start_ok) begin
            base_q <= starting_addr;
            circ_q <= circ_in;
            for (int d = 0; d < NUM_DIMS; d++) begin
                stride_q[d] <= strides[d*AW +: AW];
                max_q[d]    <= max_d[d];
            end
        end
    end

    // Control FSM with registered outputs. Reset and flush act even when
    // clk_en is low. Flush takes priority over a start in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int d = 0; d < NUM_DIMS; d++) begin
                idx_q[d] <= '0;
                off_q[d] <= '0;
            end
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        addr_q  <= starting_addr;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        for (int d = 0; d < NUM_DIMS; d++) begin
                            idx_q[d] <= '0;
                            off_q[d] <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        idx_q  <= idx_d;
                        off_q  <= off_d;
                        addr_q <= addr_d;
                        if (last_d) begin
                            done_q <= 1'b1;
                            if (!circ_q) begin
                                state_q <= S_DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd.addr_out   = addr_q;
    assign rd.addr_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_db_read_addr_gen.sv
module tb_db_read_addr_gen;
    localparam int ND = 6;
    localparam int AW = 16;
    localparam int RW = 32;

    logic              clk = 1'b0;
    logic              reset, clk_en, flush, start;
    logic [3:0]        dimensionality;
    logic [AW-1:0]     starting_addr;
    logic [ND*AW-1:0]  strides;
    logic [ND*RW-1:0]  ranges;
    logic              busy, done;
`ifdef DB_ADDR_GEN_CIRCULAR_EN
    logic              circular_en;
`endif

    int checks   = 0;
    int failures = 0;

    db_read_addr_gen_if #(.AW(AW)) rd ();

    db_read_addr_gen #(.NUM_DIMS(ND), .AW(AW), .RW(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .flush          (flush),
        .start          (start),
        .dimensionality (dimensionality),
        .starting_addr  (starting_addr),
        .strides        (strides),
        .ranges         (ranges),
`ifdef DB_ADDR_GEN_CIRCULAR_EN
        .circular_en    (circular_en),
`endif
        .rd             (rd),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string                tag;
        int                   dims;
        logic [15:0]          sa;
        logic [ND-1:0][15:0]  st;
        logic [ND-1:0][31:0]  rg;
        int                   ready_pct;
        int                   exp_len;
        logic [15:0]          exp_last;
    } vec_t;

    vec_t        vec [7];
    logic [15:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ND-1:0][15:0] pk16(int a0, int a1, int a2, int a3, int a4, int a5);
        logic [ND-1:0][15:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2);
        r[3] = 16'(a3); r[4] = 16'(a4); r[5] = 16'(a5);
        return r;
    endfunction

    function automatic logic [ND-1:0][31:0] pk32(int a0, int a1, int a2, int a3, int a4, int a5);
        logic [ND-1:0][31:0] r;
        r[0] = 32'(a0); r[1] = 32'(a1); r[2] = 32'(a2);
        r[3] = 32'(a3); r[4] = 32'(a4); r[5] = 32'(a5);
        return r;
    endfunction

    // Reference model: enumerate the sweep as a mixed-radix count and
    // compute each address directly from its digits.
    function automatic void build_exp(int dims, logic [15:0] sa,
                                      logic [ND-1:0][15:0] st, logic [ND-1:0][31:0] rg);
        int de;
        int total;
        int rem;
        int r_eff [ND];
        logic [15:0] a;
        exp_q.delete();
        de    = (dims == 0) ? 1 : ((dims > ND) ? ND : dims);
        total = 1;
        for (int d = 0; d < ND; d++) begin
            r_eff[d] = (d < de) ? ((rg[d] == 0) ? 1 : int'(rg[d])) : 1;
            total    = total * r_eff[d];
        end
        for (int n = 0; n < total; n++) begin
            rem = n;
            a   = sa;
            for (int d = 0; d < ND; d++) begin
                a   = a + 16'((rem % r_eff[d]) * int'(st[d]));
                rem = rem / r_eff[d];
            end
            exp_q.push_back(a);
        end
    endfunction

    task automatic program_cfg(int dims, logic [15:0] sa,
                               logic [ND-1:0][15:0] st, logic [ND-1:0][31:0] rg);
        dimensionality = 4'(dims);
        starting_addr  = sa;
        strides        = st;
        ranges         = rg;
    endtask

    // Consume addresses with random ready until done is seen or the budget
    // runs out. The sweep is expected to resume at exp_q[k0].
    task automatic drain(input string tag, input int k0, input int ready_pct,
                         input int exp_len, input logic [15:0] exp_last);
        int          k        = k0;
        int          budget   = 20000;
        bit          got_done = 1'b0;
        bit          stalled  = 1'b0;
        bit          accepted;
        logic [15:0] cur_a;
        logic [15:0] last_a   = '0;
        while (!got_done && budget > 0) begin
            budget--;
            if (stalled) check({tag, " valid_hold"}, 32'(rd.addr_valid), 32'd1);
            if (rd.addr_valid) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                if (k < exp_q.size()) check({tag, " addr"}, 32'(rd.addr_out), 32'(exp_q[k]));
                else                  check({tag, " extra_xfer"}, 32'(k), 32'(exp_q.size()));
            end
            rd.addr_ready = ($urandom_range(99) < ready_pct);
            accepted      = rd.addr_valid && rd.addr_ready;
            stalled       = rd.addr_valid && !rd.addr_ready;
            cur_a         = rd.addr_out;
            step();
            if (accepted) begin
                k++;
                last_a = cur_a;
            end
            got_done = done;
        end
        check({tag, " done_seen"}, 32'(got_done), 32'd1);
        check({tag, " xfers"}, 32'(k), 32'(exp_len));
        check({tag, " last_addr"}, 32'(last_a), 32'(exp_last));
        check({tag, " valid_after"}, 32'(rd.addr_valid), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic run_sweep(input string tag, input int dims, input logic [15:0] sa,
                             input logic [ND-1:0][15:0] st, input logic [ND-1:0][31:0] rg,
                             input int ready_pct, input int exp_len, input logic [15:0] exp_last);
        build_exp(dims, sa, st, rg);
        program_cfg(dims, sa, st, rg);
        rd.addr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " first_valid"}, 32'(rd.addr_valid), 32'd1);
        drain(tag, 0, ready_pct, exp_len, exp_last);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_valid"}, 32'(rd.addr_valid), 32'd0);
    endtask

    initial begin
        // Expected lengths and final addresses worked out by hand.
        vec[0] = '{"T1",       3, 16'h0000, pk16(1, 3, 9, 0, 0, 0),    pk32(3, 3, 3, 0, 0, 0), 100, 27, 16'h001A};
        vec[1] = '{"T2",       3, 16'h0000, pk16(1, 3, 9, 0, 0, 0),    pk32(3, 3, 3, 0, 0, 0),  50, 27, 16'h001A};
        vec[2] = '{"T3",       2, 16'hFFFE, pk16(1, 4, 0, 0, 0, 0),    pk32(2, 2, 0, 0, 0, 0), 100,  4, 16'h0003};
        vec[3] = '{"dims0",    0, 16'h0100, pk16(5, 1, 1, 1, 1, 1),    pk32(4, 7, 7, 7, 7, 7), 100,  4, 16'h010F};
        vec[4] = '{"range0",   2, 16'h0000, pk16(1, 10, 0, 0, 0, 0),   pk32(0, 3, 0, 0, 0, 0),  70,  3, 16'h0014};
        vec[5] = '{"dims9",    9, 16'h0000, pk16(1, 2, 4, 8, 16, 32),  pk32(2, 2, 2, 2, 2, 2),  80, 64, 16'h003F};
        vec[6] = '{"inactive", 1, 16'h0000, pk16(2, 7, 7, 7, 7, 7),    pk32(3, 5, 5, 5, 5, 5), 100,  3, 16'h0004};

        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
        rd.addr_ready = 1'b0;
        program_cfg(0, 16'h0, '0, '0);
`ifdef DB_ADDR_GEN_CIRCULAR_EN
        circular_en = 1'b0;
`endif
        step(); step();
        check("reset addr",  32'(rd.addr_out), 32'd0);
        check("reset valid", 32'(rd.addr_valid), 32'd0);
        check("reset busy",  32'(busy), 32'd0);
        check("reset done",  32'(done), 32'd0);
        reset = 1'b0;
        step();
        check("idle valid", 32'(rd.addr_valid), 32'd0);

        // Table-driven sweeps.
        for (int i = 0; i < 7; i++) begin
            run_sweep(vec[i].tag, vec[i].dims, vec[i].sa, vec[i].st, vec[i].rg,
                      vec[i].ready_pct, vec[i].exp_len, vec[i].exp_last);
        end

        // T4: flush after the 5th handshake, with start raised in the same cycle.
        build_exp(3, 16'h0, vec[0].st, vec[0].rg);
        program_cfg(3, 16'h0, vec[0].st, vec[0].rg);
        start = 1'b1;
        step();
        start = 1'b0;
        rd.addr_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("T4 addr_before_flush", 32'(rd.addr_out), 32'd5);
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        check("T4 flush valid", 32'(rd.addr_valid), 32'd0);
        check("T4 flush busy",  32'(busy), 32'd0);
        check("T4 flush done",  32'(done), 32'd0);
        check("T4 flush addr",  32'(rd.addr_out), 32'd0);
        step();
        check("T4 no_done", 32'(done), 32'd0);
        check("T4 stay_idle", 32'(rd.addr_valid), 32'd0);
        run_sweep("T4 restart", 3, 16'h0, vec[0].st, vec[0].rg, 100, 27, 16'h001A);

        // T5: clk_en freeze mid-sweep, then start held high across DONE.
        build_exp(3, 16'h0, vec[0].st, vec[0].rg);
        program_cfg(3, 16'h0, vec[0].st, vec[0].rg);
        start = 1'b1;
        step();
        rd.addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("T5 addr_pre_freeze", 32'(rd.addr_out), 32'd4);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("T5 freeze addr",  32'(rd.addr_out), 32'd4);
            check("T5 freeze valid", 32'(rd.addr_valid), 32'd1);
            check("T5 freeze busy",  32'(busy), 32'd1);
        end
        clk_en = 1'b1;
        drain("T5 a", 4, 100, 27, 16'h001A);
        step();
        check("T5 b2b done_drop", 32'(done), 32'd0);
        check("T5 b2b valid",     32'(rd.addr_valid), 32'd1);
        check("T5 b2b addr",      32'(rd.addr_out), 32'd0);
        check("T5 b2b busy",      32'(busy), 32'd1);
        start = 1'b0;
        drain("T5 b", 0, 100, 27, 16'h001A);
        step();
        check("T5 b done_one_cycle", 32'(done), 32'd0);

        // Randomized sweeps against the reference model.
        for (int it = 0; it < 6; it++) begin
            int                  dims;
            logic [15:0]         sa;
            logic [ND-1:0][15:0] st;
            logic [ND-1:0][31:0] rg;
            dims = $urandom_range(7);
            sa   = 16'($urandom);
            for (int d = 0; d < ND; d++) begin
                st[d] = 16'($urandom);
                rg[d] = 32'($urandom_range(3));
            end
            build_exp(dims, sa, st, rg);
            run_sweep("rand", dims, sa, st, rg, $urandom_range(100, 30),
                      exp_q.size(), exp_q[exp_q.size()-1]);
        end

`ifdef DB_ADDR_GEN_CIRCULAR_EN
        // T6: circular sweeps wrap without a gap; done pulses every 27 transfers.
        build_exp(3, 16'h0, vec[0].st, vec[0].rg);
        program_cfg(3, 16'h0, vec[0].st, vec[0].rg);
        circular_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        circular_en = 1'b0;
        rd.addr_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            check("T6 valid", 32'(rd.addr_valid), 32'd1);
            check("T6 addr",  32'(rd.addr_out), 32'(exp_q[n % 27]));
            check("T6 done",  32'(done), 32'((n > 0 && (n % 27) == 0) ? 1 : 0));
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("T6 flush valid", 32'(rd.addr_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
